processor_stage3_seq: RTL
=========================

Name: processor_stage3_seq

Overview:
Execute/writeback stage for the 18-bit core, extending the single-cycle stage 3 with sequential behaviour.
- Registered register-file writeback.
- Multi-cycle signed multiply-shift with pipeline stall.
- Branch, call and return resolution producing a jump request.
- Counted OP_WAIT.
- Memory-write strobe.
Sits after operand fetch (stage 2); drives the register file, data memory and the fetch unit.

Parameters:
ADDR_SIZE, 18, width of instruction/data addresses
WORD_SIZE, 18, data word width
MUL_LATENCY, 4, cycles the multiplier occupies (>=1)
WAIT_WIDTH, 11, width of the OP_WAIT counter
LINK_REG, 3'd7, register receiving the return address on OP_CALL_IMM14

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high
no_operation  in  1  current input slot empty
ip  in  ADDR_SIZE  address of the instruction in code_word
code_word  in  WORD_SIZE  instruction
alu_data0  in  WORD_SIZE  rx value
alu_data1  in  WORD_SIZE  ry value
data1_plus_imm8  in  WORD_SIZE  ry + sext(imm8)
memory_out  in  WORD_SIZE  data memory read data
stall  out  1  upstream must hold its inputs this cycle
reg_write_enable  out  1  registered write strobe
reg_write_addr  out  3  registered destination register
reg_write_data  out  WORD_SIZE  registered write data
mem_write_enable  out  1  combinational store strobe
mem_write_addr  out  ADDR_SIZE  data1_plus_imm8[ADDR_SIZE-1:0]
mem_write_data  out  WORD_SIZE  alu_data0
jump_valid  out  1  registered one-cycle jump pulse
jump_addr  out  ADDR_SIZE  registered jump target

Behaviour:
- One clock; reset is asynchronous and active-high. Reset clears all registered outputs, state and counters to 0; state goes to RUN.
- An instruction is accepted when state==RUN, no_operation==0 and jump_valid==0.
  - The cycle after jump_valid is asserted, the input slot is squashed (one-slot flush).
- Writeback latency is 1 cycle after accept. For MUL it is 1 cycle after completion.
  - reg_write_enable is a single-cycle pulse.
  - reg_write_addr = code_word[13:11], except on CALL where it is LINK_REG.
- Writeback per opcode:
  - ADD_IMM8 → data1_plus_imm8.
  - MOV_IMM11 → sext(imm11).
  - MOV_IMM11_TOP → {imm11, 7'd0}.
  - LOAD → memory_out.
  - ALU → alu result for op code_word[3:0].
- WRITE_TO_MEMORY: mem_write_enable=1 in the accept cycle only. It is never asserted while stalled, squashed or with no_operation.
- OP_IF:
  - Condition code_word[10:8] applied to rx as signed: 0 ==0, 1 !=0, 2 <0, 3 >=0, 4 >0, 5 <=0, 6/7 never.
  - Taken: jump_valid=1 next cycle, jump_addr = ip + sext(code_word[7:0]), modulo 2^ADDR_SIZE.
- CALL_IMM14: jump_addr = zext(code_word[13:0]); writes ip+1 (mod 2^ADDR_SIZE) to LINK_REG in the same cycle as jump_valid.
- RETURN: jump_addr = memory_out[ADDR_SIZE-1:0].
- MUL_SHIFT:
  - Accept latches rx, ry and shift = code_word[4:0], then enters MUL.
  - stall=1 combinationally for MUL_LATENCY-1 further cycles.
  - Result = low WORD_SIZE bits of (signed rx * signed ry) >>> shift (arithmetic shift, 2*WORD_SIZE product).
  - Returns to RUN; writeback follows.
  - MUL_LATENCY==1: no stall.
- WAIT: loads counter with code_word[WAIT_WIDTH-1:0] and enters WAIT.
  - stall=1 while counter!=0; the counter decrements each cycle.
  - Returns to RUN when the count is 0.
  - Count 0: no stall.
- Other opcodes: no effect.
- stall==0 whenever state==RUN.
- Reset mid-MUL or mid-WAIT aborts the operation with no writeback.

Optional Feature:
STAGE3_STALL_COUNT_EN
- Defined: adds output stall_cycles [31:0], counting cycles with stall==1. It saturates at all-ones and is cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Opcode constants (OP_*), the IF condition enum, the state enum (RUN, MUL, WAIT) and field-slice helpers go in the shared processor package.
- Sub-module mulxx_seq holds the multi-cycle multiply-shift datapath, with a start/done handshake and MUL_LATENCY as a parameter.
- The existing combinational alu is instantiated unchanged.

Test Plan:
1. MOV_IMM11 rx=2, imm11=11'h7FF → next cycle: reg_write_enable=1, addr=2, data=18'h3FFFF; no stall.
2. MUL_SHIFT, rx=-3, ry=5, shift=1, MUL_LATENCY=4 → stall high 3 cycles; writeback data=18'h3FFF8 (-8) one cycle after the MUL state ends.
3. IF cond=2, rx=-1, ip=100, imm8=8'hFC → jump_valid pulse with jump_addr=96; the following input slot produces no write or store.
4. CALL_IMM14 imm=0x1234, ip=0x3FFFF → jump_addr=0x1234; LINK_REG written with 0.
5. WAIT count=5 → stall=1 for 5 cycles; a STORE presented during the stall does not assert mem_write_enable until accepted.
6. Assert reset in the 2nd MUL cycle → all outputs 0 immediately; no writeback after reset is released.

Source files
------------

// File: rtl/processor_stage3_seq_pkg.sv
// Shared definitions for the 18-bit core stage 3: opcodes, IF conditions,
// sequencer states, ALU op codes and instruction field slices.
package processor_stage3_seq_pkg;

    localparam int INSTR_W = 18;

    typedef enum logic [3:0] {
        OP_ADD_IMM8        = 4'd0,
        OP_MOV_IMM11       = 4'd1,
        OP_MOV_IMM11_TOP   = 4'd2,
        OP_LOAD            = 4'd3,
        OP_ALU             = 4'd4,
        OP_WRITE_TO_MEMORY = 4'd5,
        OP_IF              = 4'd6,
        OP_CALL_IMM14      = 4'd7,
        OP_RETURN          = 4'd8,
        OP_MUL_SHIFT       = 4'd9,
        OP_WAIT            = 4'd10
    } opcode_t;

    typedef enum logic [2:0] {
        IF_EQ_ZERO = 3'd0,
        IF_NE_ZERO = 3'd1,
        IF_LT_ZERO = 3'd2,
        IF_GE_ZERO = 3'd3,
        IF_GT_ZERO = 3'd4,
        IF_LE_ZERO = 3'd5,
        IF_NEVER6  = 3'd6,
        IF_NEVER7  = 3'd7
    } if_cond_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MUL  = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOT  = 4'd5,
        ALU_SHL  = 4'd6,
        ALU_SHR  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_MOVB = 4'd9,
        ALU_SLT  = 4'd10,
        ALU_SLTU = 4'd11
    } alu_op_t;

    function automatic opcode_t f_opcode(input logic [INSTR_W-1:0] w);
        return opcode_t'(w[17:14]);
    endfunction

    function automatic logic [2:0] f_rd(input logic [INSTR_W-1:0] w);
        return w[13:11];
    endfunction

    function automatic if_cond_t f_cond(input logic [INSTR_W-1:0] w);
        return if_cond_t'(w[10:8]);
    endfunction

    function automatic logic [7:0] f_imm8(input logic [INSTR_W-1:0] w);
        return w[7:0];
    endfunction

    function automatic logic [10:0] f_imm11(input logic [INSTR_W-1:0] w);
        return w[10:0];
    endfunction

    function automatic logic [13:0] f_imm14(input logic [INSTR_W-1:0] w);
        return w[13:0];
    endfunction

    function automatic logic [4:0] f_shift(input logic [INSTR_W-1:0] w);
        return w[4:0];
    endfunction

    function automatic logic [3:0] f_alu_op(input logic [INSTR_W-1:0] w);
        return w[3:0];
    endfunction

    // Conditions are evaluated on rx as a signed value.
    function automatic logic if_taken(input if_cond_t c, input logic neg, input logic zero);
        case (c)
            IF_EQ_ZERO: return zero;
            IF_NE_ZERO: return !zero;
            IF_LT_ZERO: return neg;
            IF_GE_ZERO: return !neg;
            IF_GT_ZERO: return !neg && !zero;
            IF_LE_ZERO: return neg || zero;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/processor_stage3_seq_alu.sv
// Combinational ALU of the 18-bit core, selected by code_word[3:0].
module alu
    import processor_stage3_seq_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (alu_op_t'(op))
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOT:  result = ~a;
            ALU_SHL:  result = a << b[4:0];
            ALU_SHR:  result = a >> b[4:0];
            ALU_SRA:  result = WIDTH'($signed(a) >>> b[4:0]);
            ALU_MOVB: result = b;
            ALU_SLT:  result = WIDTH'($signed(a) < $signed(b));
            ALU_SLTU: result = WIDTH'(a < b);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/processor_stage3_seq_mulxx_seq.sv
// Multi-cycle signed multiply with arithmetic right shift; start latches the
// operands, done marks the cycle whose result is valid.
module mulxx_seq #(
    parameter int WIDTH   = 18,
    parameter int LATENCY = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shift,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [4:0]       shift_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [4:0]       op_shift;
    logic signed [2*WIDTH-1:0] prod;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            shift_q <= '0;
            cnt     <= '0;
        end else if (start) begin
            a_q     <= a;
            b_q     <= b;
            shift_q <= shift;
            cnt     <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // A single-cycle multiplier completes in the start cycle from live operands.
    always_comb begin
        op_a     = start ? a     : a_q;
        op_b     = start ? b     : b_q;
        op_shift = start ? shift : shift_q;
        done     = (LATENCY == 1) ? start : (cnt == CNT_W'(1));
        prod     = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a}) * $signed({{WIDTH{op_b[WIDTH-1]}}, op_b});
        result   = WIDTH'(prod >>> op_shift);
    end

endmodule

// File: rtl/processor_stage3_seq.sv
// Execute/writeback stage 3 with registered writeback, multi-cycle multiply,
// counted wait and jump resolution. Optional: STAGE3_STALL_COUNT_EN adds stall_cycles.
//
// state | meaning
// RUN   | accepting instructions, no stall
// MUL   | multiplier busy, upstream stalled
// WAIT  | OP_WAIT counter non-zero, upstream stalled
module processor_stage3_seq
    import processor_stage3_seq_pkg::*;
#(
    parameter int         ADDR_SIZE   = 18,
    parameter int         WORD_SIZE   = 18,
    parameter int         MUL_LATENCY = 4,
    parameter int         WAIT_WIDTH  = 11,
    parameter logic [2:0] LINK_REG    = 3'd7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 no_operation,
    input  logic [ADDR_SIZE-1:0] ip,
    input  logic [WORD_SIZE-1:0] code_word,
    input  logic [WORD_SIZE-1:0] alu_data0,
    input  logic [WORD_SIZE-1:0] alu_data1,
    input  logic [WORD_SIZE-1:0] data1_plus_imm8,
    input  logic [WORD_SIZE-1:0] memory_out,
    output logic                 stall,
    output logic                 reg_write_enable,
    output logic [2:0]           reg_write_addr,
    output logic [WORD_SIZE-1:0] reg_write_data,
    output logic                 mem_write_enable,
    output logic [ADDR_SIZE-1:0] mem_write_addr,
    output logic [WORD_SIZE-1:0] mem_write_data,
    output logic                 jump_valid,
    output logic [ADDR_SIZE-1:0] jump_addr
`ifdef STAGE3_STALL_COUNT_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);

    state_t                state;
    state_t                state_next;
    opcode_t               opcode;
    logic [2:0]            rd;
    logic [10:0]           imm11;
    logic [7:0]            imm8;
    logic                  accept;
    logic                  cond_ok;
    logic [WAIT_WIDTH-1:0] wait_cnt;
    logic                  wait_load;
    logic                  mul_start;
    logic                  mul_done;
    logic [WORD_SIZE-1:0]  mul_result;
    logic [2:0]            mul_dest;
    logic [WORD_SIZE-1:0]  alu_result;
    logic [ADDR_SIZE-1:0]  ip_plus1;
    logic                  wb_en_d;
    logic [2:0]            wb_addr_d;
    logic [WORD_SIZE-1:0]  wb_data_d;
    logic                  jump_d;
    logic [ADDR_SIZE-1:0]  jump_addr_d;

    assign opcode   = f_opcode(code_word);
    assign rd       = f_rd(code_word);
    assign imm11    = f_imm11(code_word);
    assign imm8     = f_imm8(code_word);
    assign ip_plus1 = ip + ADDR_SIZE'(1);
    assign cond_ok  = if_taken(f_cond(code_word), alu_data0[WORD_SIZE-1], alu_data0 == '0);

    // The slot right after a jump is the wrong path and is dropped.
    assign accept    = (state == RUN) && !no_operation && !jump_valid;
    assign mul_start = accept && (opcode == OP_MUL_SHIFT);
    assign wait_load = accept && (opcode == OP_WAIT);

    assign mem_write_enable = accept && (opcode == OP_WRITE_TO_MEMORY);
    assign mem_write_addr   = data1_plus_imm8[ADDR_SIZE-1:0];
    assign mem_write_data   = alu_data0;

    alu #(
        .WIDTH (WORD_SIZE)
    ) u_alu (
        .op     (f_alu_op(code_word)),
        .a      (alu_data0),
        .b      (alu_data1),
        .result (alu_result)
    );

    mulxx_seq #(
        .WIDTH   (WORD_SIZE),
        .LATENCY (MUL_LATENCY)
    ) u_mul (
        .clock  (clock),
        .reset  (reset),
        .start  (mul_start),
        .a      (alu_data0),
        .b      (alu_data1),
        .shift  (f_shift(code_word)),
        .done   (mul_done),
        .result (mul_result)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (mul_start && (MUL_LATENCY > 1)) begin
                    state_next = MUL;
                end else if (wait_load && (code_word[WAIT_WIDTH-1:0] != '0)) begin
                    state_next = WAIT;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_next = RUN;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_WIDTH'(1)) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        stall = (state == MUL) || (state == WAIT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (wait_load) begin
            wait_cnt <= code_word[WAIT_WIDTH-1:0];
        end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mul_dest <= '0;
        end else if (mul_start) begin
            mul_dest <= rd;
        end
    end

    always_comb begin
        wb_en_d     = 1'b0;
        wb_addr_d   = rd;
        wb_data_d   = '0;
        jump_d      = 1'b0;
        jump_addr_d = '0;
        if (accept) begin
            case (opcode)
                OP_ADD_IMM8: begin
                    wb_en_d   = 1'b1;
                    wb_data_d = data1_plus_imm8;
                end
                OP_MOV_IMM11: begin
                    wb_en_d   = 1'b1;
                    wb_data_d = {{(WORD_SIZE-11){imm11[10]}}, imm11};
                end
                OP_MOV_IMM11_TOP: begin
                    wb_en_d   = 1'b1;
                    wb_data_d = WORD_SIZE'({imm11, 7'd0});
                end
                OP_LOAD: begin
                    wb_en_d   = 1'b1;
                    wb_data_d = memory_out;
                end
                OP_ALU: begin
                    wb_en_d   = 1'b1;
                    wb_data_d = alu_result;
                end
                OP_IF: begin
                    jump_d      = cond_ok;
                    jump_addr_d = ip + {{(ADDR_SIZE-8){imm8[7]}}, imm8};
                end
                OP_CALL_IMM14: begin
                    jump_d      = 1'b1;
                    jump_addr_d = {{(ADDR_SIZE-14){1'b0}}, f_imm14(code_word)};
                    wb_en_d     = 1'b1;
                    wb_addr_d   = LINK_REG;
                    wb_data_d   = WORD_SIZE'(ip_plus1);
                end
                OP_RETURN: begin
                    jump_d      = 1'b1;
                    jump_addr_d = memory_out[ADDR_SIZE-1:0];
                end
                default: ;
            endcase
        end
        // With a single-cycle multiplier, done coincides with the accept cycle.
        if (mul_done) begin
            wb_en_d   = 1'b1;
            wb_addr_d = mul_start ? rd : mul_dest;
            wb_data_d = mul_result;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_write_enable <= 1'b0;
            reg_write_addr   <= '0;
            reg_write_data   <= '0;
            jump_valid       <= 1'b0;
            jump_addr        <= '0;
        end else begin
            reg_write_enable <= wb_en_d;
            jump_valid       <= jump_d;
            if (wb_en_d) begin
                reg_write_addr <= wb_addr_d;
                reg_write_data <= wb_data_d;
            end
            if (jump_d) begin
                jump_addr <= jump_addr_d;
            end
        end
    end

`ifdef STAGE3_STALL_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
